// File: rtl/cim_mem_arbiter.sv
// Fixed-priority arbiter from the seven CiM access sources onto the single-port
// temp-result SRAM, with tagged read return and sticky conflict accounting.
module cim_mem_arbiter #(
  parameter int NUM_SRC = 7,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          read_req_src,
  input  logic [NUM_SRC-1:0]          write_req_src,
  input  logic [NUM_SRC*ADDR_W-1:0]   addr_table,
  input  logic [NUM_SRC*DATA_W-1:0]   write_data,
  input  logic                        flush,
  input  logic                        err_clr,
  output logic [NUM_SRC-1:0]          grant,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        rd_valid,
  output logic [NUM_SRC-1:0]          rd_src,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        conflict_err,
  output logic [7:0]                  conflict_cnt
);

  // Request/grant: a source raises its request with operands and must hold both
  // until it sees its grant bit; the access is taken on the following edge.
  logic [NUM_SRC-1:0] req;
  logic               any_req;
  logic               win_we;
  logic               win_rd;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic               conflict;

  assign req     = read_req_src | write_req_src;
  assign grant   = req & ~(req - NUM_SRC'(1));
  assign any_req = |req;
  // Same-source read+write performs the write and drops the read.
  assign win_rd  = |(grant & read_req_src & ~write_req_src);
  assign conflict = (|(req & (req - NUM_SRC'(1)))) | (|(read_req_src & write_req_src));

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        win_we    = write_req_src[i];
        win_addr  = addr_table[i*ADDR_W +: ADDR_W];
        win_wdata = write_data[i*DATA_W +: DATA_W];
      end
    end
  end

  logic                          mem_en_q, mem_en_d;
  logic                          mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]             mem_wdata_q, mem_wdata_d;
  logic [RD_LAT-1:0][NUM_SRC:0]  tag_q, tag_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [NUM_SRC-1:0]            rd_src_q, rd_src_d;
  logic [DATA_W-1:0]             rd_data_q, rd_data_d;
  logic                          conflict_err_q, conflict_err_d;
  logic [7:0]                    conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    mem_en_d    = any_req;
    mem_we_d    = any_req & win_we;
    mem_addr_d  = any_req ? win_addr  : mem_addr_q;
    mem_wdata_d = any_req ? win_wdata : mem_wdata_q;

    // Tag entry = {valid, one-hot owner}; the oldest entry lines up with mem_rdata.
    tag_d    = '0;
    tag_d[0] = flush ? '0 : {win_rd, (win_rd ? grant : {NUM_SRC{1'b0}})};
    for (int k = 1; k < RD_LAT; k++) begin
      tag_d[k] = flush ? '0 : tag_q[k-1];
    end
    rd_valid_d = ~flush & tag_q[RD_LAT-1][NUM_SRC];
    rd_src_d   = rd_valid_d ? tag_q[RD_LAT-1][NUM_SRC-1:0] : '0;
    rd_data_d  = rd_valid_d ? mem_rdata : rd_data_q;

    conflict_err_d = conflict_err_q;
    conflict_cnt_d = conflict_cnt_q;
    if (err_clr) begin
      conflict_err_d = 1'b0;
      conflict_cnt_d = '0;
    end else if (conflict) begin
      conflict_err_d = 1'b1;
      if (conflict_cnt_q != 8'hFF) conflict_cnt_d = conflict_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      tag_q          <= '0;
      rd_valid_q     <= 1'b0;
      rd_src_q       <= '0;
      rd_data_q      <= '0;
      conflict_err_q <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      tag_q          <= tag_d;
      rd_valid_q     <= rd_valid_d;
      rd_src_q       <= rd_src_d;
      rd_data_q      <= rd_data_d;
      conflict_err_q <= conflict_err_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rd_valid     = rd_valid_q;
  assign rd_src       = rd_src_q;
  assign rd_data      = rd_data_q;
  assign conflict_err = conflict_err_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Bench for cim_mem_arbiter: directed scenarios plus random traffic, checked
// against a cycle-level model of the arbitration and read-return rules.
module tb_cim_mem_arbiter;
  localparam int NS = 7;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int RL = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     read_req_src = '0;
  logic [NS-1:0]     write_req_src = '0;
  logic [NS*AW-1:0]  addr_table = '0;
  logic [NS*DW-1:0]  write_data = '0;
  logic              flush = 1'b0;
  logic              err_clr = 1'b0;
  logic [NS-1:0]     grant;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata, rd_data;
  logic              rd_valid, conflict_err;
  logic [NS-1:0]     rd_src;
  logic [7:0]        conflict_cnt;

  cim_mem_arbiter #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .read_req_src(read_req_src), .write_req_src(write_req_src),
    .addr_table(addr_table), .write_data(write_data), .flush(flush), .err_clr(err_clr),
    .grant(grant), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_src(rd_src),
    .rd_data(rd_data), .conflict_err(conflict_err), .conflict_cnt(conflict_cnt)
  );

  // clock / reset / SRAM with read data valid in the cycle after the command edge
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] sram [2**AW];
  logic [DW-1:0] model_mem [2**AW];
  assign mem_rdata = sram[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [NS+DW-1:0] exp_q[$];
  int               due_q[$];
  logic             exp_en, exp_we, exp_err;
  logic [AW-1:0]    exp_addr;
  logic [DW-1:0]    exp_wdata;
  int               exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 32'h1357) ^ 16'hA5A5;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    due_q.delete();
    exp_en = 0; exp_we = 0; exp_err = 0;
    exp_addr = '0; exp_wdata = '0; exp_cnt = 0;
  endtask

  task automatic clear_reqs();
    read_req_src = '0; write_req_src = '0; flush = 0; err_clr = 0;
  endtask

  task automatic set_src(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    read_req_src[i]       = rd;
    write_req_src[i]      = wr;
    addr_table[i*AW +: AW] = a;
    write_data[i*DW +: DW] = d;
  endtask

  // driver: inputs are set just after a negedge; the model predicts, then the
  // registered outputs are checked at the next negedge
  task automatic cycle_run();
    int w, nreq;
    bit conf;
    logic [AW-1:0] a;
    #1;
    w = -1; nreq = 0; conf = 0;
    for (int i = 0; i < NS; i++) begin
      if (read_req_src[i] || write_req_src[i]) begin
        nreq++;
        if (w < 0) w = i;
      end
      if (read_req_src[i] && write_req_src[i]) conf = 1;
    end
    if (nreq > 1) conf = 1;
    check("grant", 32'(grant), (w < 0) ? 32'd0 : (32'd1 << w));
    if (err_clr) begin
      exp_cnt = 0; exp_err = 0;
    end else if (conf) begin
      exp_err = 1;
      if (exp_cnt < 255) exp_cnt++;
    end
    if (flush) begin
      exp_q.delete();
      due_q.delete();
    end
    if (w < 0) begin
      exp_en = 0; exp_we = 0;
    end else begin
      a = addr_table[w*AW +: AW];
      exp_en = 1; exp_we = write_req_src[w];
      exp_addr = a; exp_wdata = write_data[w*DW +: DW];
      if (write_req_src[w]) model_mem[a] = exp_wdata;
      else if (!flush) begin
        exp_q.push_back({NS'(1) << w, model_mem[a]});
        due_q.push_back(cyc + 1 + RL);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("mem_en", 32'(mem_en), 32'(exp_en));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    check("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    check("conflict_err", 32'(conflict_err), 32'(exp_err));
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      logic [NS+DW-1:0] e;
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_src", 32'(rd_src), 32'(e[NS+DW-1:DW]));
      check("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
    end else begin
      check("rd_valid_idle", 32'(rd_valid), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    clear_reqs();
    for (int k = 0; k < n; k++) cycle_run();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_rd_src"}, 32'(rd_src), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_err"}, 32'(conflict_err), 0);
    check({tag, "_cnt"}, 32'(conflict_cnt), 0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      sram[i] = init_val(i);
      model_mem[i] = init_val(i);
    end
    sram[11'h123] = 16'hBEEF;
    model_mem[11'h123] = 16'hBEEF;
    model_reset();
    clear_reqs();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_grant", 32'(grant), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single read by MAC
    set_src(4, 1, 0, 11'h123, 16'h0);
    cycle_run();
    clear_reqs();
    cycle_run();
    check("single_rd_data", 32'(rd_data), 32'hBEEF);
    idle(2);

    // write then read-after-write to the same address
    set_src(2, 0, 1, 11'h010, 16'h7FFF);
    cycle_run();
    set_src(2, 1, 0, 11'h010, 16'h0);
    cycle_run();
    idle(3);

    // contention between sources 1 and 5, both holding until granted
    set_src(1, 1, 0, 11'h021, 16'h0);
    set_src(5, 1, 0, 11'h022, 16'h0);
    cycle_run();
    read_req_src[1] = 0;
    cycle_run();
    idle(3);

    // same-source read+write, then err_clr
    set_src(0, 1, 1, 11'h055, 16'h0001);
    cycle_run();
    clear_reqs();
    err_clr = 1;
    cycle_run();
    idle(2);

    // flush one cycle after a read issue
    set_src(3, 1, 0, 11'h033, 16'h0);
    cycle_run();
    clear_reqs();
    flush = 1;
    cycle_run();
    idle(3);

    // conflict burst saturates the counter; err_clr beats a same-cycle conflict
    set_src(0, 1, 0, 11'h001, 16'h0);
    set_src(1, 1, 0, 11'h002, 16'h0);
    for (int k = 0; k < 300; k++) cycle_run();
    check("sat_cnt", 32'(conflict_cnt), 32'd255);
    err_clr = 1;
    cycle_run();
    idle(3);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      clear_reqs();
      for (int i = 0; i < NS; i++) begin
        set_src(i, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                AW'($urandom_range(0, 15)), DW'($urandom));
      end
      flush   = ($urandom_range(0, 19) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      cycle_run();
    end
    idle(3);

    // async reset with a read in flight
    set_src(6, 1, 0, 11'h044, 16'h0);
    cycle_run();
    clear_reqs();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
